// File: rtl/led_status_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_status_pkg
// Purpose : Shared definitions for the reg_led_status LED peripheral: mode
//           codes, mode-byte field positions, reset mode value and the
//           per-channel output selection function.
// Ports   : none (package)
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
package led_status_pkg;

  typedef enum logic [2:0] {
    LED_OFF        = 3'd0,
    LED_ON         = 3'd1,
    LED_ACT        = 3'd2,
    LED_BLINK_SLOW = 3'd3,
    LED_BLINK_FAST = 3'd4,
    LED_ACT_INV    = 3'd5
  } led_mode_e;

  localparam int         LED_INV_BIT    = 7;
  localparam logic [2:0] LED_MODE_MASK  = 3'b111;
  localparam logic [7:0] LED_MODE_RESET = 8'h02;

  // Raw (pre-register) LED value for one channel. Codes 6 and 7 fall into
  // the default branch and behave as OFF; the INVERT bit applies to every
  // mode, including OFF.
  function automatic logic led_mode_out(
    input logic [7:0] mode,
    input logic       stretched,
    input logic       slow,
    input logic       fast
  );
    logic [2:0] code;
    logic       f;
    code = mode[2:0] & LED_MODE_MASK;
    case (code)
      LED_ON:         f = 1'b1;
      LED_ACT:        f = stretched;
      LED_BLINK_SLOW: f = slow;
      LED_BLINK_FAST: f = fast;
      LED_ACT_INV:    f = ~stretched;
      default:        f = 1'b0;
    endcase
    return mode[LED_INV_BIT] ^ f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_stretch_ch.sv
`default_nettype none
// ============================================================================
// Module  : led_stretch_ch
// Purpose : One LED activity stretcher. A saturating counter is cleared by
//           activity and counts up to its idle value (MSB set), so the
//           channel reads as "stretched" for 2^(STRETCH_BITS-1) cycles after
//           the last activity sample.
// Ports   : clk          system clock
//           reset_i      synchronous active-high reset
//           act_i        activity level for this channel
//           stretched_o  high while the stretch window is open
// Config  : LED_ACT_SYNC_EN - insert a 2-flop synchronizer on act_i
// Revision: 1.0  initial release
// ============================================================================
module led_stretch_ch #(
  parameter int STRETCH_BITS = 18
) (
  input  logic clk,
  input  logic reset_i,
  input  logic act_i,
  output logic stretched_o
);
  import led_status_pkg::*;

  localparam logic [STRETCH_BITS-1:0] c_idle = {1'b1, {(STRETCH_BITS-1){1'b0}}};

  logic                    w_act;
  logic [STRETCH_BITS-1:0] r_cnt;

`ifdef LED_ACT_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= act_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_act = r_sync2;
`else
  assign w_act = act_i;
`endif

  // Counting stops once the MSB is set, so the counter saturates at idle
  // and never wraps back into the stretch window.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_cnt <= c_idle;
    end else if (w_act) begin
      r_cnt <= '0;
    end else if (!r_cnt[STRETCH_BITS-1]) begin
      r_cnt <= r_cnt + STRETCH_BITS'(1);
    end
  end

  assign stretched_o = ~r_cnt[STRETCH_BITS-1];

endmodule
`default_nettype wire

// File: rtl/reg_led_status.sv
`default_nettype none
// ============================================================================
// Module  : reg_led_status
// Purpose : Register-bus LED peripheral. One mode byte per channel selects
//           OFF / ON / activity-stretch / slow blink / fast blink / inverted
//           activity, with a per-channel INVERT bit. LED outputs are
//           registered.
// Ports   : clk, reset_i            clock, synchronous active-high reset
//           reg_address/bytecnt/datai/read/write/addrvalid   bus inputs
//           reg_size               transfer size (unused)
//           reg_datao              read data, 0 when not selected
//           reg_hypaddress         length-query address
//           reg_hyplen             register length, 0 when not selected
//           reg_stream             tied 0
//           act_i[NUM_CH]          per-channel activity
//           led_o[NUM_CH]          registered LED drive
// Config  : LED_ACT_SYNC_EN - synchronize act_i (adds 2 cycles latency)
// Revision: 1.0  initial release
// ============================================================================
module reg_led_status #(
  parameter int         NUM_CH       = 6,
  parameter int         STRETCH_BITS = 18,
  parameter int         BLINK_BITS   = 24,
  parameter logic [5:0] ADDR_LEDMODE = 6'd52
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [5:0]        reg_address,
  input  logic [15:0]       reg_bytecnt,
  input  logic [7:0]        reg_datai,
  output logic [7:0]        reg_datao,
  input  logic [15:0]       reg_size,
  input  logic              reg_read,
  input  logic              reg_write,
  input  logic              reg_addrvalid,
  input  logic [5:0]        reg_hypaddress,
  output logic [15:0]       reg_hyplen,
  output logic              reg_stream,
  input  logic [NUM_CH-1:0] act_i,
  output logic [NUM_CH-1:0] led_o
);
  import led_status_pkg::*;

  logic [7:0]            r_mode [NUM_CH];
  logic [BLINK_BITS-1:0] r_presc;
  logic [NUM_CH-1:0]     w_stretched;
  logic                  w_sel;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_slow;
  logic                  w_fast;
  logic                  w_unused;

  assign w_sel = reg_addrvalid & (reg_address == ADDR_LEDMODE);
  assign w_wr  = reg_write & w_sel;
  assign w_rd  = reg_read & w_sel;

  // Mode register file. A byte index outside 0..NUM_CH-1 matches no
  // channel, so out-of-range writes fall through with no effect.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_mode[ch] <= LED_MODE_RESET;
      end
    end else if (w_wr) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (reg_bytecnt == 16'(ch)) begin
          r_mode[ch] <= reg_datai;
        end
      end
    end
  end

  always_comb begin
    reg_datao = 8'h00;
    if (w_rd) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (reg_bytecnt == 16'(ch)) begin
          reg_datao = r_mode[ch];
        end
      end
    end
  end

  assign reg_hyplen = (reg_hypaddress == ADDR_LEDMODE) ? 16'(NUM_CH) : 16'h0000;
  assign reg_stream = 1'b0;

  // Shared blink prescaler.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + BLINK_BITS'(1);
    end
  end

  assign w_slow = r_presc[BLINK_BITS-1];
  assign w_fast = r_presc[BLINK_BITS-3];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_stretch_ch #(
      .STRETCH_BITS (STRETCH_BITS)
    ) u_stretch (
      .clk         (clk),
      .reset_i     (reset_i),
      .act_i       (act_i[g]),
      .stretched_o (w_stretched[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      led_o <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        led_o[ch] <= led_mode_out(r_mode[ch], w_stretched[ch], w_slow, w_fast);
      end
    end
  end

  assign w_unused = ^{reg_size, r_presc};

endmodule
`default_nettype wire

// File: tb/tb_reg_led_status.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_led_status
// Purpose : Self-checking bench for reg_led_status (NUM_CH=6,
//           STRETCH_BITS=4, BLINK_BITS=4). Bus behaviour is driven from a
//           vector table; stretch, blink and reset sequences are hand-written.
// Config  : LED_ACT_SYNC_EN - expected activity latency grows by 2 cycles
// Revision: 1.0  initial release
// ============================================================================
module tb_reg_led_status;

  localparam int         NCH  = 6;
  localparam logic [5:0] ADDR = 6'd52;
`ifdef LED_ACT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic [5:0]     reg_address = '0;
  logic [15:0]    reg_bytecnt = '0;
  logic [7:0]     reg_datai = '0;
  logic [7:0]     reg_datao;
  logic [15:0]    reg_size = '0;
  logic           reg_read = 1'b0;
  logic           reg_write = 1'b0;
  logic           reg_addrvalid = 1'b0;
  logic [5:0]     reg_hypaddress = '0;
  logic [15:0]    reg_hyplen;
  logic           reg_stream;
  logic [NCH-1:0] act_i = '0;
  logic [NCH-1:0] led_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_led_status #(
    .NUM_CH       (NCH),
    .STRETCH_BITS (4),
    .BLINK_BITS   (4),
    .ADDR_LEDMODE (ADDR)
  ) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_size       (reg_size),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_hypaddress (reg_hypaddress),
    .reg_hyplen     (reg_hyplen),
    .reg_stream     (reg_stream),
    .act_i          (act_i),
    .led_o          (led_o)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic        av;
    logic [5:0]  addr;
    logic [15:0] bc;
    logic [7:0]  di;
    logic [7:0]  exp_do;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] bc, input logic [7:0] d);
    reg_address   = ADDR;
    reg_addrvalid = 1'b1;
    reg_bytecnt   = bc;
    reg_datai     = d;
    reg_write     = 1'b1;
    step();
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic bus_read_chk(input string name, input logic [15:0] bc, input logic [7:0] exp);
    reg_address   = ADDR;
    reg_addrvalid = 1'b1;
    reg_bytecnt   = bc;
    reg_read      = 1'b1;
    #1;
    chk(name, 32'(reg_datao), 32'(exp));
    reg_read      = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  function automatic logic in_win(input int j, input int p);
    return (p >= 0) && (j >= p + 1 + LAT) && (j <= p + 8 + LAT);
  endfunction

  // Pulses act_i[ch] before edge k (j=0) and optionally before edge k+p1,
  // then checks led_o[ch] after each edge k+j against the stretch window.
  task automatic run_pulses(input int ch, input int p1, input int n, input logic inv);
    logic e;
    for (int j = 0; j <= n; j++) begin
      act_i[ch] = (j == 0) || (j == p1);
      step();
      act_i[ch] = 1'b0;
      e = inv ^ (in_win(j, 0) | in_win(j, p1));
      chk($sformatf("stretch ch%0d j=%0d", ch, j), 32'(led_o[ch]), 32'(e));
    end
  endtask

  initial begin
    logic s [48];
    int   bad;

    // ---------------- reset ----------------
    reset_i = 1'b1;
    repeat (3) step();
    chk("reset led_o", 32'(led_o), 32'h0);
    chk("reset reg_stream", 32'(reg_stream), 32'h0);
    reset_i = 1'b0;
    step();
    chk("post-reset led_o", 32'(led_o), 32'h0);

    reg_hypaddress = ADDR;        #1; chk("hyplen match", 32'(reg_hyplen), 32'd6);
    reg_hypaddress = 6'd51;       #1; chk("hyplen 51", 32'(reg_hyplen), 32'd0);
    reg_hypaddress = 6'd0;        #1; chk("hyplen 0", 32'(reg_hyplen), 32'd0);
    reg_hypaddress = 6'd53;       #1; chk("hyplen 53", 32'(reg_hyplen), 32'd0);

    // ---------------- bus vector table ----------------
    for (int b = 0; b < NCH; b++) vq.push_back('{1'b0, 1'b1, 1'b1, ADDR, 16'(b), 8'h00, 8'h02});
    vq.push_back('{1'b1, 1'b0, 1'b1, ADDR,  16'd2,     8'h01, 8'h00});
    vq.push_back('{1'b0, 1'b1, 1'b1, ADDR,  16'd2,     8'h00, 8'h01});
    vq.push_back('{1'b1, 1'b0, 1'b1, ADDR,  16'd6,     8'hFF, 8'h00});
    vq.push_back('{1'b0, 1'b1, 1'b1, ADDR,  16'd6,     8'h00, 8'h00});
    vq.push_back('{1'b0, 1'b1, 1'b1, ADDR,  16'd0,     8'h00, 8'h02});
    vq.push_back('{1'b0, 1'b1, 1'b1, ADDR,  16'd5,     8'h00, 8'h02});
    vq.push_back('{1'b1, 1'b0, 1'b0, ADDR,  16'd1,     8'h55, 8'h00});
    vq.push_back('{1'b0, 1'b1, 1'b1, ADDR,  16'd1,     8'h00, 8'h02});
    vq.push_back('{1'b1, 1'b0, 1'b1, 6'd51, 16'd0,     8'hAA, 8'h00});
    vq.push_back('{1'b0, 1'b1, 1'b1, ADDR,  16'd0,     8'h00, 8'h02});
    vq.push_back('{1'b0, 1'b1, 1'b1, 6'd51, 16'd2,     8'h00, 8'h00});
    vq.push_back('{1'b0, 1'b1, 1'b0, ADDR,  16'd2,     8'h00, 8'h00});
    vq.push_back('{1'b0, 1'b0, 1'b1, ADDR,  16'd2,     8'h00, 8'h00});
    vq.push_back('{1'b0, 1'b1, 1'b1, ADDR,  16'h0102,  8'h00, 8'h00});
    vq.push_back('{1'b1, 1'b0, 1'b1, ADDR,  16'h0100,  8'h07, 8'h00});
    vq.push_back('{1'b0, 1'b1, 1'b1, ADDR,  16'd0,     8'h00, 8'h02});
    vq.push_back('{1'b1, 1'b0, 1'b1, ADDR,  16'd5,     8'h7A, 8'h00});
    vq.push_back('{1'b0, 1'b1, 1'b1, ADDR,  16'd5,     8'h00, 8'h7A});
    vq.push_back('{1'b1, 1'b0, 1'b1, ADDR,  16'd5,     8'h02, 8'h00});
    vq.push_back('{1'b0, 1'b1, 1'b1, ADDR,  16'd5,     8'h00, 8'h02});

    foreach (vq[i]) begin
      reg_write     = vq[i].wr;
      reg_read      = vq[i].rd;
      reg_addrvalid = vq[i].av;
      reg_address   = vq[i].addr;
      reg_bytecnt   = vq[i].bc;
      reg_datai     = vq[i].di;
      #1;
      chk($sformatf("bus vec %0d datao", i), 32'(reg_datao), 32'(vq[i].exp_do));
      step();
      reg_write     = 1'b0;
      reg_read      = 1'b0;
      reg_addrvalid = 1'b0;
    end

    // ---------------- single pulse and retrigger ----------------
    run_pulses(0, -1, 12, 1'b0);
    run_pulses(0, 5, 20, 1'b0);
    bad = 0;
    for (int j = 0; j < 120; j++) begin
      step();
      if (led_o[0] !== 1'b0) bad++;
    end
    chk("no wrap after saturation", 32'(bad), 32'd0);

    // ---------------- modes ----------------
    chk("ch2 ON", 32'(led_o[2]), 32'd1);
    bus_write(16'd2, 8'h81);
    step();
    chk("ch2 ON inverted", 32'(led_o[2]), 32'd0);

    bus_write(16'd1, 8'h82);
    step();
    chk("ch1 ACT inverted idle", 32'(led_o[1]), 32'd1);
    bus_write(16'd1, 8'h02);
    step();
    chk("ch1 ACT idle", 32'(led_o[1]), 32'd0);

    bus_write(16'd4, 8'h05);
    step();
    chk("ch4 ACT_INV idle", 32'(led_o[4]), 32'd1);
    run_pulses(4, -1, 12, 1'b1);

    bus_write(16'd3, 8'h03);
    step();
    for (int t = 0; t < 48; t++) begin
      s[t] = led_o[3];
      step();
    end
    bad = 0;
    for (int t = 0; t < 32; t++) begin
      if (s[t + 16] !== s[t] || s[t + 8] === s[t]) bad++;
    end
    chk("slow blink period 16", 32'(bad), 32'd0);

    bus_write(16'd3, 8'h04);
    step();
    for (int t = 0; t < 48; t++) begin
      s[t] = led_o[3];
      step();
    end
    bad = 0;
    for (int t = 0; t < 40; t++) begin
      if (s[t + 4] !== s[t] || s[t + 2] === s[t]) bad++;
    end
    chk("fast blink period 4", 32'(bad), 32'd0);

    bus_write(16'd3, 8'h07);
    step();
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      if (led_o[3] !== 1'b0) bad++;
      step();
    end
    chk("code 7 off", 32'(bad), 32'd0);

    bus_write(16'd5, 8'h06);
    act_i[5] = 1'b1;
    step();
    step();
    chk("code 6 off with activity", 32'(led_o[5]), 32'd0);
    act_i[5] = 1'b0;

    // ---------------- reset mid-operation ----------------
    act_i[0] = 1'b1;
    repeat (4) step();
    chk("ch0 lit while act held", 32'(led_o[0]), 32'd1);
    reset_i = 1'b1;
    step();
    chk("reset mid-stretch led_o", 32'(led_o), 32'h0);
    step();
    chk("reset held led_o", 32'(led_o), 32'h0);
    bus_read_chk("reset restores mode3", 16'd3, 8'h02);
    act_i   = '0;
    reset_i = 1'b0;
    step();
    chk("post-reset act discarded 1", 32'(led_o), 32'h0);
    step();
    chk("post-reset act discarded 2", 32'(led_o), 32'h0);
    run_pulses(0, -1, 12, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
